// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared definitions for the memory-access pipeline stage:
//                opcode and funct3 encodings, exception codes, FSM state
//                type and the access-legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam int OPC_W = 5;
    localparam int F3_W  = 3;
    localparam int REG_W = 5;

    // Major opcodes (instruction bits [6:2])
    localparam logic [OPC_W-1:0] OPC_LOAD  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STORE = 5'b01000;

    // Load/store size and sign encodings
    localparam logic [F3_W-1:0] F3_BYTE  = 3'd0;
    localparam logic [F3_W-1:0] F3_HALF  = 3'd1;
    localparam logic [F3_W-1:0] F3_WORD  = 3'd2;
    localparam logic [F3_W-1:0] F3_BYTEU = 3'd4;
    localparam logic [F3_W-1:0] F3_HALFU = 3'd5;

    // Exception codes
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // True when funct3 names a legal size for the access kind and the
    // address is naturally aligned for it. Undefined encodings are illegal
    // and are reported as misaligned.
    function automatic logic access_ok(input logic [F3_W-1:0] f3,
                                       input logic [1:0]      addr_lo,
                                       input logic            is_store);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_BYTE:  ok = 1'b1;
            F3_HALF:  ok = ~addr_lo[0];
            F3_WORD:  ok = (addr_lo == 2'b00);
            F3_BYTEU: ok = ~is_store;
            F3_HALFU: ok = ~is_store & ~addr_lo[0];
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_load_align
//  Description : Combinational load lane selection. Picks the byte or
//                halfword addressed by i_addr_lo out of the read word and
//                sign- or zero-extends it according to i_funct3.
//  Ports       : i_rdata   - read word from data memory
//                i_addr_lo - low two address bits of the access
//                i_funct3  - load size/sign encoding
//                o_result  - aligned, extended load value
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_load_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_addr_lo,
    input  logic [F3_W-1:0]   i_funct3,
    output logic [DATA_W-1:0] o_result
);

    logic [DATA_W-1:0] w_shifted;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // Shifting the addressed lane down to bit 0 serves both sizes: halfword
    // accesses are known to be 2-byte aligned by the time they get here.
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    always_comb begin
        o_result = i_rdata;
        case (i_funct3)
            F3_BYTE:  o_result = {{(DATA_W-8){w_byte[7]}}, w_byte};
            F3_BYTEU: o_result = {{(DATA_W-8){1'b0}}, w_byte};
            F3_HALF:  o_result = {{(DATA_W-16){w_half[15]}}, w_half};
            F3_HALFU: o_result = {{(DATA_W-16){1'b0}}, w_half};
            default:  o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : Memory-access pipeline stage. Passes non-memory work to
//                writeback after one cycle, checks load/store alignment,
//                issues a single outstanding data-memory request and holds
//                it until acknowledged, then forms the writeback result.
//  Ports       : clk, reset (sync, active-low)
//                in_*    - instruction from execute (valid/ready handshake)
//                dmem_*  - data-memory request/response
//                wb_*    - registered writeback-stage inputs, wb_valid pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int EX_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    // execute-stage input
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   in_opcode,
    input  logic [F3_W-1:0]    in_funct3,
    input  logic               in_nop,
    input  logic [DATA_W-1:0]  in_result,
    input  logic [DATA_W-1:0]  in_store_data,
    input  logic [REG_W-1:0]   in_rd_addr,
    input  logic               in_exception_valid,
    input  logic [EX_W-1:0]    in_exception,
    input  logic               in_halt,
    // data memory
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic [3:0]         dmem_be,
    input  logic               dmem_ack,
    input  logic               dmem_err,
    input  logic [DATA_W-1:0]  dmem_rdata,
    // writeback stage
    output logic               wb_valid,
    output logic [OPC_W-1:0]   wb_opcode,
    output logic               wb_nop,
    output logic [DATA_W-1:0]  wb_result,
    output logic [REG_W-1:0]   wb_rd_addr,
    output logic               wb_exception_valid,
    output logic [EX_W-1:0]    wb_exception,
    output logic               wb_halt
);

    state_t             r_state;
    state_t             w_state_next;

    // transaction context held across the WAIT state
    logic [ADDR_W-1:0]  r_addr;
    logic [F3_W-1:0]    r_funct3;
    logic               r_is_store;
    logic [OPC_W-1:0]   r_opcode;
    logic [REG_W-1:0]   r_rd_addr;

    logic               r_dmem_req;
    logic               r_dmem_we;
    logic [ADDR_W-1:0]  r_dmem_addr;
    logic [DATA_W-1:0]  r_dmem_wdata;
    logic [3:0]         r_dmem_be;

    logic               r_wb_valid;
    logic [OPC_W-1:0]   r_wb_opcode;
    logic               r_wb_nop;
    logic [DATA_W-1:0]  r_wb_result;
    logic [REG_W-1:0]   r_wb_rd_addr;
    logic               r_wb_exception_valid;
    logic [EX_W-1:0]    r_wb_exception;
    logic               r_wb_halt;

    logic               w_accept;
    logic               w_is_mem;
    logic               w_is_store;
    logic               w_access_ok;
    logic               w_start;
    logic               w_done;
    logic [3:0]         w_be;
    logic [DATA_W-1:0]  w_wdata;
    logic [DATA_W-1:0]  w_load_data;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready;

    // Anything flagged upstream (exception, NOP, halt) bypasses memory.
    assign w_is_mem    = !in_nop && !in_exception_valid && !in_halt &&
                         ((in_opcode == OPC_LOAD) || (in_opcode == OPC_STORE));
    assign w_is_store  = (in_opcode == OPC_STORE);
    assign w_access_ok = access_ok(in_funct3, in_result[1:0], w_is_store);
    assign w_start     = w_accept && w_is_mem && w_access_ok;
    assign w_done      = (r_state == ST_WAIT) && dmem_ack;

    // store lane enables and replicated write data
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = in_store_data;
        case (in_funct3)
            F3_BYTE: begin
                w_be    = 4'b0001 << in_result[1:0];
                w_wdata = {(DATA_W/8){in_store_data[7:0]}};
            end
            F3_HALF: begin
                w_be    = 4'b0011 << in_result[1:0];
                w_wdata = {(DATA_W/16){in_store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = in_store_data;
            end
        endcase
    end

    mem_access_load_align #(
        .DATA_W    (DATA_W)
    ) u_load_align (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_result  (w_load_data)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start)  w_state_next = ST_WAIT;
            ST_WAIT: if (dmem_ack) w_state_next = ST_IDLE;
            default:               w_state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------- memory request / context
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_be    <= 4'b0000;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_is_store   <= 1'b0;
            r_opcode     <= '0;
            r_rd_addr    <= '0;
        end else if (w_start) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= w_is_store;
            r_dmem_addr  <= {in_result[ADDR_W-1:2], 2'b00};
            r_dmem_wdata <= w_is_store ? w_wdata : '0;
            r_dmem_be    <= w_is_store ? w_be : 4'b0000;
            r_addr       <= in_result[ADDR_W-1:0];
            r_funct3     <= in_funct3;
            r_is_store   <= w_is_store;
            r_opcode     <= in_opcode;
            r_rd_addr    <= in_rd_addr;
        end else if (w_done) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= 4'b0000;
        end
    end

    // ----------------------------------------------------------- writeback
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wb_valid           <= 1'b0;
            r_wb_opcode          <= '0;
            r_wb_nop             <= 1'b0;
            r_wb_result          <= '0;
            r_wb_rd_addr         <= '0;
            r_wb_exception_valid <= 1'b0;
            r_wb_exception       <= '0;
            r_wb_halt            <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            if (w_accept && !w_start) begin
                // bypass path: plain pass-through or a misaligned access
                r_wb_valid   <= 1'b1;
                r_wb_opcode  <= in_opcode;
                r_wb_nop     <= in_nop;
                r_wb_result  <= in_result;
                r_wb_rd_addr <= in_rd_addr;
                r_wb_halt    <= in_halt;
                if (w_is_mem) begin
                    r_wb_exception_valid <= 1'b1;
                    r_wb_exception       <= w_is_store ? EX_W'(EXC_STORE_MISALIGN)
                                                       : EX_W'(EXC_LOAD_MISALIGN);
                end else begin
                    r_wb_exception_valid <= in_exception_valid;
                    r_wb_exception       <= in_exception;
                end
            end else if (w_done) begin
                r_wb_valid   <= 1'b1;
                r_wb_opcode  <= r_opcode;
                r_wb_nop     <= 1'b0;
                r_wb_rd_addr <= r_rd_addr;
                r_wb_halt    <= 1'b0;
                if (dmem_err) begin
                    r_wb_exception_valid <= 1'b1;
                    r_wb_exception       <= r_is_store ? EX_W'(EXC_STORE_FAULT)
                                                       : EX_W'(EXC_LOAD_FAULT);
                    r_wb_result          <= DATA_W'(r_addr);
                end else begin
                    r_wb_exception_valid <= 1'b0;
                    r_wb_exception       <= '0;
                    r_wb_result          <= r_is_store ? DATA_W'(r_addr) : w_load_data;
                end
            end
        end
    end

    assign dmem_req           = r_dmem_req;
    assign dmem_we            = r_dmem_we;
    assign dmem_addr          = r_dmem_addr;
    assign dmem_wdata         = r_dmem_wdata;
    assign dmem_be            = r_dmem_be;

    assign wb_valid           = r_wb_valid;
    assign wb_opcode          = r_wb_opcode;
    assign wb_nop             = r_wb_nop;
    assign wb_result          = r_wb_result;
    assign wb_rd_addr         = r_wb_rd_addr;
    assign wb_exception_valid = r_wb_exception_valid;
    assign wb_exception       = r_wb_exception;
    assign wb_halt            = r_wb_halt;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Self-checking bench for mem_access. Directed cases for the
//                documented scenarios followed by randomized instructions,
//                each checked against a behavioural model of the stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam logic [4:0] C_OP_LOAD  = 5'h00;
    localparam logic [4:0] C_OP_STORE = 5'h08;
    localparam logic [4:0] C_OP_IMM   = 5'h04;
    localparam logic [4:0] C_OP_REG   = 5'h0C;
    localparam logic [4:0] C_OP_LUI   = 5'h0D;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_nop;
    logic [31:0] in_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd_addr;
    logic        in_exception_valid;
    logic [3:0]  in_exception;
    logic        in_halt;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        dmem_err;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_opcode;
    logic        wb_nop;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd_addr;
    logic        wb_exception_valid;
    logic [3:0]  wb_exception;
    logic        wb_halt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access #(
        .ADDR_W (32),
        .DATA_W (32),
        .EX_W   (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_opcode          (in_opcode),
        .in_funct3          (in_funct3),
        .in_nop             (in_nop),
        .in_result          (in_result),
        .in_store_data      (in_store_data),
        .in_rd_addr         (in_rd_addr),
        .in_exception_valid (in_exception_valid),
        .in_exception       (in_exception),
        .in_halt            (in_halt),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_ack           (dmem_ack),
        .dmem_err           (dmem_err),
        .dmem_rdata         (dmem_rdata),
        .wb_valid           (wb_valid),
        .wb_opcode          (wb_opcode),
        .wb_nop             (wb_nop),
        .wb_result          (wb_result),
        .wb_rd_addr         (wb_rd_addr),
        .wb_exception_valid (wb_exception_valid),
        .wb_exception       (wb_exception),
        .wb_halt            (wb_halt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------- reference model
    // Access size in bytes for a load/store encoding, 0 when undefined.
    function automatic int access_size(input logic [4:0] op, input logic [2:0] f3);
        if (op == C_OP_LOAD) begin
            case (f3)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2:       return 4;
                default:    return 0;
            endcase
        end else begin
            case (f3)
                3'd0:    return 1;
                3'd1:    return 2;
                3'd2:    return 4;
                default: return 0;
            endcase
        end
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] word, input int lane,
                                               input logic [2:0] f3);
        logic [31:0] v;
        v = word >> (8 * lane);
        case (f3)
            3'd0: return (v & 32'hFF)   | (v[7]  ? 32'hFFFF_FF00 : 32'h0);
            3'd4: return  v & 32'hFF;
            3'd1: return (v & 32'hFFFF) | (v[15] ? 32'hFFFF_0000 : 32'h0);
            3'd5: return  v & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    task automatic idle_inputs();
        in_valid           = 1'b0;
        in_opcode          = 5'h0;
        in_funct3          = 3'h0;
        in_nop             = 1'b0;
        in_result          = 32'h0;
        in_store_data      = 32'h0;
        in_rd_addr         = 5'h0;
        in_exception_valid = 1'b0;
        in_exception       = 4'h0;
        in_halt            = 1'b0;
    endtask

    // Presents one instruction, plays the memory side with the given ack
    // delay/err/rdata, and checks everything the model predicts.
    task automatic run_instr(input logic [4:0] op, input logic [2:0] f3, input logic nop,
                             input logic [31:0] res, input logic [31:0] sdata,
                             input logic [4:0] rd, input logic exv, input logic [3:0] exc,
                             input logic halt, input int delay, input logic err,
                             input logic [31:0] rdata);
        bit          is_mem, is_st, goes_mem;
        int          sz, lane, low_cnt;
        logic [31:0] e_res, e_wd;
        logic        e_exv;
        logic [3:0]  e_exc, e_be;

        is_mem   = ((op == C_OP_LOAD) || (op == C_OP_STORE)) && !nop && !exv && !halt;
        is_st    = (op == C_OP_STORE);
        sz       = access_size(op, f3);
        lane     = int'(res % 4);
        goes_mem = is_mem && (sz != 0) && ((res % sz) == 0);

        chk("in_ready_idle", in_ready, 1'b1);
        in_valid           = 1'b1;
        in_opcode          = op;
        in_funct3          = f3;
        in_nop             = nop;
        in_result          = res;
        in_store_data      = sdata;
        in_rd_addr         = rd;
        in_exception_valid = exv;
        in_exception       = exc;
        in_halt            = halt;
        @(posedge clk); #1;
        idle_inputs();

        if (!goes_mem) begin
            if (is_mem) begin
                e_exv = 1'b1;
                e_exc = is_st ? 4'd6 : 4'd4;
            end else begin
                e_exv = exv;
                e_exc = exc;
            end
            e_res = res;
            chk("no_dmem_req", dmem_req, 1'b0);
        end else begin
            e_be = 4'(((1 << sz) - 1) << lane);
            e_wd = (sz == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                   (sz == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
            chk("dmem_req", dmem_req, 1'b1);
            chk("dmem_addr", dmem_addr, res & ~32'h3);
            chk("dmem_we", dmem_we, is_st);
            if (is_st) begin
                chk("dmem_be", dmem_be, e_be);
                chk("dmem_wdata", dmem_wdata, e_wd);
            end
            low_cnt = 0;
            for (int d = 0; d <= delay; d++) begin
                if (!in_ready) low_cnt++;
                if (d > 0) begin
                    chk("dmem_req_hold", dmem_req, 1'b1);
                    chk("dmem_addr_hold", dmem_addr, res & ~32'h3);
                end
                if (d == delay) begin
                    dmem_ack   = 1'b1;
                    dmem_err   = err;
                    dmem_rdata = rdata;
                end else begin
                    dmem_rdata = $urandom;
                end
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                dmem_err = 1'b0;
            end
            chk("ready_low_cycles", low_cnt, delay + 1);
            chk("dmem_req_drop", dmem_req, 1'b0);
            chk("in_ready_back", in_ready, 1'b1);
            if (err) begin
                e_exv = 1'b1;
                e_exc = is_st ? 4'd7 : 4'd5;
                e_res = res;
            end else begin
                e_exv = 1'b0;
                e_exc = 4'd0;
                e_res = is_st ? res : load_value(rdata, lane, f3);
            end
        end

        chk("wb_valid", wb_valid, 1'b1);
        chk("wb_opcode", wb_opcode, op);
        chk("wb_nop", wb_nop, nop);
        chk("wb_rd_addr", wb_rd_addr, rd);
        chk("wb_halt", wb_halt, halt);
        chk("wb_exc_valid", wb_exception_valid, e_exv);
        if (e_exv) chk("wb_exception", wb_exception, e_exc);
        chk("wb_result", wb_result, e_res);

        @(posedge clk); #1;
        chk("wb_pulse", wb_valid, 1'b0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [4:0]  op_tab [7];
        logic [2:0]  f3_tab [5];
        logic [4:0]  r_op;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        logic        r_exv;

        op_tab = '{C_OP_LOAD, C_OP_LOAD, C_OP_STORE, C_OP_STORE, C_OP_IMM, C_OP_REG, C_OP_LUI};
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        idle_inputs();
        dmem_ack   = 1'b0;
        dmem_err   = 1'b0;
        dmem_rdata = 32'h0;
        reset      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_exc_valid", wb_exception_valid, 1'b0);
        chk("rst_wb_halt", wb_halt, 1'b0);
        chk("rst_wb_result", wb_result, 32'h0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_dmem_be", dmem_be, 4'b0000);
        reset = 1'b1;
        @(posedge clk); #1;

        // ADDI x5 -> pass-through
        run_instr(C_OP_IMM, 3'd0, 1'b0, 32'h10, 32'h0, 5'd5, 1'b0, 4'd0, 1'b0, 0, 1'b0, 32'h0);
        // LB 0x103, ack after 3 wait cycles, sign-extended 0x80
        run_instr(C_OP_LOAD, 3'd0, 1'b0, 32'h103, 32'h0, 5'd7, 1'b0, 4'd0, 1'b0, 3, 1'b0,
                  32'h80FF_FF7F);
        chk("lb_result_const", wb_result, 32'hFFFF_FF80);
        // SH 0x202 with data 0x1234ABCD
        run_instr(C_OP_STORE, 3'd1, 1'b0, 32'h202, 32'h1234_ABCD, 5'd0, 1'b0, 4'd0, 1'b0, 1,
                  1'b0, 32'h0);
        // LW 0x101 -> misaligned load, code 4
        run_instr(C_OP_LOAD, 3'd2, 1'b0, 32'h101, 32'h0, 5'd9, 1'b0, 4'd0, 1'b0, 0, 1'b0, 32'h0);
        // LHU, unknown load funct3, unknown store funct3, halt, upstream exception
        run_instr(C_OP_LOAD, 3'd5, 1'b0, 32'h0000_0402, 32'h0, 5'd3, 1'b0, 4'd0, 1'b0, 0, 1'b0,
                  32'h8765_4321);
        run_instr(C_OP_LOAD, 3'd3, 1'b0, 32'h400, 32'h0, 5'd3, 1'b0, 4'd0, 1'b0, 0, 1'b0, 32'h0);
        run_instr(C_OP_STORE, 3'd4, 1'b0, 32'h400, 32'h0, 5'd0, 1'b0, 4'd0, 1'b0, 0, 1'b0, 32'h0);
        run_instr(C_OP_LOAD, 3'd2, 1'b0, 32'h500, 32'h0, 5'd1, 1'b0, 4'd0, 1'b1, 0, 1'b0, 32'h0);
        run_instr(C_OP_STORE, 3'd2, 1'b0, 32'h600, 32'h0, 5'd0, 1'b1, 4'd2, 1'b0, 0, 1'b0, 32'h0);
        // SW with access fault -> code 7
        run_instr(C_OP_STORE, 3'd2, 1'b0, 32'h300, 32'hDEAD_BEEF, 5'd0, 1'b0, 4'd0, 1'b0, 2,
                  1'b1, 32'h0);

        // LW abandoned by reset while waiting for ack
        chk("abort_ready", in_ready, 1'b1);
        in_valid   = 1'b1;
        in_opcode  = C_OP_LOAD;
        in_funct3  = 3'd2;
        in_result  = 32'h700;
        in_rd_addr = 5'd4;
        @(posedge clk); #1;
        idle_inputs();
        chk("abort_req_up", dmem_req, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_dmem_req", dmem_req, 1'b0);
        chk("abort_wb_valid", wb_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_wb_exc", wb_exception_valid, 1'b0);
        chk("abort_wb_result", wb_result, 32'h0);
        reset    = 1'b1;
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("abort_no_wb", wb_valid, 1'b0);
        chk("abort_idle_req", dmem_req, 1'b0);

        // randomized mix
        for (int i = 0; i < 120; i++) begin
            r_op = op_tab[$urandom_range(0, 6)];
            r_f3 = ($urandom_range(0, 3) != 0) ? f3_tab[$urandom_range(0, 4)]
                                               : 3'($urandom_range(0, 7));
            r_addr = $urandom;
            if ($urandom_range(0, 1) == 0) r_addr = r_addr & ~32'h3;
            r_exv = ($urandom_range(0, 9) == 0);
            run_instr(r_op, r_f3, ($urandom_range(0, 9) == 0), r_addr, $urandom,
                      5'($urandom_range(0, 31)), r_exv,
                      r_exv ? 4'($urandom_range(0, 15)) : 4'd0,
                      ($urandom_range(0, 19) == 0), $urandom_range(0, 4),
                      ($urandom_range(0, 4) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
